run_detect_sched: RTL and testbench
===================================

Name: run_detect_sched

Overview:
- Time-multiplexed scheduler and context manager for a shared two-ones run detector (states S0..S3, S3 saturating).
- Arbitrates NCH serial bit streams round-robin and feeds one granted bit per cycle into a single detector evaluation.
- Saves and restores each channel's 2-bit detector state from a per-channel context array.
- Emits a registered per-bit result tagged with the channel index. Sits between the per-lane bit sources and the event/interrupt collector.

Parameters:
- NCH, 4, number of requesting channels (legal 2..16).
- CW, $clog2(NCH), channel index width (derived; never overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 = no grants, contexts held.
- in_valid  input  NCH  per-channel bit available.
- in_bit  input  NCH  per-channel serial data bit.
- in_ready  output  NCH  one-hot grant; a bit transfers when in_valid[i] & in_ready[i].
- clr  input  NCH  per-channel context clear (to S0).
- out_valid  output  1  result valid (one-cycle pulse per consumed bit).
- out_chan  output  CW  channel of the result.
- out_hit  output  1  consumed bit moved that channel S1->S2 (second consecutive 1).
- out_state  output  2  channel's new detector state after the bit (S0=0, S1=1, S2=2, S3=3).

Behaviour:
- Reset and clock:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - Reset values: all contexts S0; rr pointer = NCH-1, so channel 0 has first priority; out_valid=0, out_chan=0, out_hit=0, out_state=0.
  - in_ready is combinational and is 0 while rst=1.
- Eligibility and grant:
  - Channel i is eligible when en & in_valid[i] & ~clr[i].
  - Grant is the first eligible channel searching ptr+1, ptr+2, ... modulo NCH.
  - in_ready is the one-hot grant, combinational from in_valid/clr/en/ptr. No eligible channel gives all zeros.
  - Sources must not make in_valid depend on in_ready.
- Pointer: after a grant, ptr <= granted index. With no grant, ptr holds.
- Detector next-state for granted channel g, with context s and bit b:
  - S0: b ? S1 : S0.
  - S1: b ? S2 : S0.
  - S2: b ? S3 : S0.
  - S3: b ? S3 : S0.
  - Any 0 returns to S0.
- Write-back: ctx[g] <= next state, in the same edge as the transfer.
- Result output, registered with 1-cycle latency. At the edge after a transfer on g:
  - out_valid=1, out_chan=g.
  - out_state = next state.
  - out_hit = (s==S1 & b==1).
  - In cycles with no transfer, out_valid=0 and out_chan/out_hit/out_state hold their previous values. out_hit is only meaningful while out_valid=1.
- Clear:
  - clr[i]=1 sets ctx[i] <= S0 at the edge and makes channel i ineligible that cycle (clr wins over data; that bit is not consumed).
  - Multiple clr bits may be set at once.
  - clr is honoured even when en=0.
- en=0: no grants, ptr held, out_valid=0 next cycle, contexts held except for clr.
- Contexts are independent: interleaving channels never alters another channel's state.
- Saturation: repeated 1s hold S3 with out_hit=0. Only the S1->S2 step ever produces a hit.
- Reset mid-stream: all contexts return to S0 and ptr returns to NCH-1. Any in-flight result is dropped (out_valid=0 the next cycle).
- Fairness: with all channels continuously valid, each channel is granted exactly once every NCH cycles.

Test Plan:
- Reset release, NCH=4, all in_valid=1 constant, in_bit=1:
  - Grants in order ch0,1,2,3,0,... one per cycle.
  - Each channel's 2nd result gives out_hit=1, out_state=2; its 3rd gives out_state=3, out_hit=0.
- Only ch2 valid, bit sequence 1,1,0,1,1,1:
  - out_state 1,2,0,1,2,3.
  - out_hit pulses on the 2nd and 5th results.
  - out_chan=2 throughout, each result 1 cycle after its transfer.
- Context isolation:
  - ch0 sends 1, ch1 sends 0, ch0 sends 1 (interleaved).
  - ch0's second result has out_hit=1 despite ch1's intervening 0.
- Clear collision:
  - ch1 in S1 with in_valid=1, in_bit=1, clr[1]=1 in the same cycle.
  - in_ready[1]=0, no result; ctx[1]=S0.
  - The next bit 1 gives out_state=1, out_hit=0.
- en toggling:
  - en=0 for 3 cycles with all valid: in_ready=0, out_valid=0, ptr held.
  - Re-enabling resumes from the channel after the last granted one.
- Reset mid-stream:
  - Assert rst for 1 cycle while ch3 is in S2.
  - Next cycle out_valid=0 and ch0 is granted first.
  - The next ch3 bit 1 gives out_state=1.

Source files
------------

// File: rtl/run_detect_sched_if.sv
// Bundle between the per-lane bit sources / result collector and the shared
// run-detector scheduler. clk and rst stay outside as plain ports.
interface run_detect_sched_if #(
  parameter int NCH = 4
);
  localparam int CW = $clog2(NCH);

  // Handshake: a bit on lane i transfers on the rising edge where
  // in_valid[i] & in_ready[i] are both 1. in_ready is a combinational one-hot
  // grant and in_valid must not depend on it. out_valid is a one-cycle pulse
  // per consumed bit with no back-pressure.
  logic           en;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_bit;
  logic [NCH-1:0] in_ready;
  logic [NCH-1:0] clr;
  logic           out_valid;
  logic [CW-1:0]  out_chan;
  logic           out_hit;
  logic [1:0]     out_state;
  logic [CW-1:0]  dbg_ptr;

  modport master (
    output en, in_valid, in_bit, clr,
    input  in_ready, out_valid, out_chan, out_hit, out_state, dbg_ptr
  );

  modport slave (
    input  en, in_valid, in_bit, clr,
    output in_ready, out_valid, out_chan, out_hit, out_state, dbg_ptr
  );
endinterface

// File: rtl/run_detect_sched.sv
// Round-robin scheduler feeding one granted bit per cycle into a shared
// two-ones run detector, with per-channel saved detector context.
module run_detect_sched #(
  parameter int NCH = 4
) (
  input logic               clk,
  input logic               rst,
  run_detect_sched_if.slave bus
);
  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} det_t;

  det_t           ctx [NCH];
  logic [CW-1:0]  ptr;
  logic           out_valid_q;
  logic [CW-1:0]  out_chan_q;
  logic           out_hit_q;
  det_t           out_state_q;

  logic [NCH-1:0] elig;
  logic [NCH-1:0] grant;
  logic           found;
  logic [CW-1:0]  gidx;
  logic [CW-1:0]  cand;
  det_t           cur;
  det_t           nxt;
  logic           b;

  // Search starts one past the last granted channel, so it gets lowest priority.
  always_comb begin
    elig  = bus.in_valid & ~bus.clr & {NCH{bus.en}};
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CW'((int'(ptr) + k) % NCH);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    grant = found ? (NCH'(1) << gidx) : '0;
  end

  always_comb begin
    cur = ctx[gidx];
    b   = bus.in_bit[gidx];
    nxt = S0;
    if (b) begin
      case (cur)
        S0:      nxt = S1;
        S1:      nxt = S2;
        default: nxt = S3;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) ctx[i] <= S0;
      ptr         <= CW'(NCH - 1);
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_hit_q   <= 1'b0;
      out_state_q <= S0;
    end else begin
      out_valid_q <= found;
      // A cleared channel is never granted the same cycle, so these writes never collide.
      for (int i = 0; i < NCH; i++) begin
        if (bus.clr[i]) ctx[i] <= S0;
      end
      if (found) begin
        ctx[gidx]   <= nxt;
        ptr         <= gidx;
        out_chan_q  <= gidx;
        out_hit_q   <= (cur == S1) && b;
        out_state_q <= nxt;
      end
    end
  end

  assign bus.in_ready  = rst ? '0 : grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_state = out_state_q;
  assign bus.dbg_ptr   = ptr;
endmodule

// File: tb/tb_run_detect_sched.sv
// Bench for run_detect_sched: directed scenarios plus random traffic, all
// scored against a behavioural model of the scheduling and run-detect rules.
module tb_run_detect_sched;
  localparam int NCH = 4;
  localparam int CW  = $clog2(NCH);
  localparam int W   = CW + 3;

  logic clk;
  logic rst;

  run_detect_sched_if #(.NCH(NCH)) bus ();

  run_detect_sched #(.NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int             n_checks;
  int             n_fail;
  logic [W-1:0]   exp_q[$];

  // Behavioural model
  int             m_ctx [NCH];
  int             m_ptr;
  logic           m_valid;
  int             m_chan;
  int             m_hit;
  int             m_state;

  // Last sampled DUT values, for directed checks
  logic [NCH-1:0] last_ready;
  logic           last_valid;
  logic [CW-1:0]  last_chan;
  logic           last_hit;
  logic [1:0]     last_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_ctx[i] = 0;
    m_ptr   = NCH - 1;
    m_valid = 1'b0;
    m_chan  = 0;
    m_hit   = 0;
    m_state = 0;
    exp_q.delete();
  endtask

  function automatic int model_grant(input logic e, input logic [NCH-1:0] v, input logic [NCH-1:0] c);
    int idx;
    if (!e) return -1;
    for (int k = 1; k <= NCH; k++) begin
      idx = (m_ptr + k) % NCH;
      if (v[idx] && !c[idx]) return idx;
    end
    return -1;
  endfunction

  // Driver: apply one cycle of inputs, check the DUT, then advance the model.
  task automatic step(input logic r, input logic e, input logic [NCH-1:0] v,
                      input logic [NCH-1:0] bits, input logic [NCH-1:0] c);
    int             g;
    int             s;
    int             ns;
    logic [NCH-1:0] exp_ready;
    logic [W-1:0]   exp_res;
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.in_valid = v;
    bus.in_bit   = bits;
    bus.clr      = c;
    #1;
    last_ready = bus.in_ready;
    last_valid = bus.out_valid;
    last_chan  = bus.out_chan;
    last_hit   = bus.out_hit;
    last_state = bus.out_state;

    g = model_grant(e, v, c);
    exp_ready = '0;
    if (!r && g >= 0) exp_ready[g] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("ptr", 32'(bus.dbg_ptr), 32'(m_ptr));
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("result_queue_empty", 32'(1), 32'(0));
      end else begin
        exp_res = exp_q.pop_front();
        check("result", 32'({bus.out_chan, bus.out_hit, bus.out_state}), 32'(exp_res));
      end
    end else begin
      check("hold", 32'({bus.out_chan, bus.out_hit, bus.out_state}),
            32'({CW'(m_chan), m_hit[0], 2'(m_state)}));
    end

    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) if (c[i]) m_ctx[i] = 0;
      m_valid = (g >= 0);
      if (g >= 0) begin
        s  = m_ctx[g];
        ns = bits[g] ? ((s + 1 > 3) ? 3 : s + 1) : 0;
        m_ctx[g] = ns;
        m_ptr    = g;
        m_chan   = g;
        m_hit    = (s == 1 && bits[g]) ? 1 : 0;
        m_state  = ns;
        exp_q.push_back({CW'(m_chan), m_hit[0], 2'(m_state)});
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b1, '0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, '0, '0, '0);
  endtask

  int seq_bits [6] = '{1, 1, 0, 1, 1, 1};
  int seq_st   [6] = '{1, 2, 0, 1, 2, 3};
  int seq_hit  [6] = '{0, 1, 0, 0, 1, 0};

  initial begin
    logic [NCH-1:0] one_hot;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.in_valid = '0;
    bus.in_bit   = '0;
    bus.clr      = '0;
    model_reset();
    do_reset();
    do_reset();

    // All channels valid with 1s: strict rotation from ch0, hit on each 2nd result.
    for (int k = 0; k < 13; k++) begin
      step(1'b0, 1'b1, '1, '1, '0);
      one_hot = NCH'(1) << (k % NCH);
      check("rr_grant", 32'(last_ready), 32'(one_hot));
      if (k >= NCH + 1 && k <= 2 * NCH) begin
        check("rr_second_hit", 32'(last_hit), 32'(1));
        check("rr_second_state", 32'(last_state), 32'(2));
      end
      if (k >= 2 * NCH + 1) begin
        check("rr_third_hit", 32'(last_hit), 32'(0));
        check("rr_third_state", 32'(last_state), 32'(3));
      end
    end

    // Only ch2 valid, bits 1,1,0,1,1,1.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, (i < 6) ? 4'b0100 : 4'b0000,
           (i < 6 && seq_bits[i] != 0) ? 4'b0100 : 4'b0000, '0);
      if (i > 0) begin
        check("ch2_valid", 32'(last_valid), 32'(1));
        check("ch2_chan", 32'(last_chan), 32'(2));
        check("ch2_state", 32'(last_state), 32'(seq_st[i-1]));
        check("ch2_hit", 32'(last_hit), 32'(seq_hit[i-1]));
      end
    end

    // Context isolation: ch0=1, ch1=0, ch0=1.
    do_reset();
    step(1'b0, 1'b1, 4'b0001, 4'b0001, '0);
    step(1'b0, 1'b1, 4'b0010, 4'b0000, '0);
    step(1'b0, 1'b1, 4'b0001, 4'b0001, '0);
    idle();
    check("iso_hit", 32'(last_hit), 32'(1));
    check("iso_chan", 32'(last_chan), 32'(0));

    // Clear collides with data on ch1 sitting in S1.
    do_reset();
    step(1'b0, 1'b1, 4'b0010, 4'b0010, '0);
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0010);
    check("clr_ready", 32'(last_ready), 32'(0));
    step(1'b0, 1'b1, 4'b0010, 4'b0010, '0);
    check("clr_no_result", 32'(last_valid), 32'(0));
    idle();
    check("clr_state", 32'(last_state), 32'(1));
    check("clr_hit", 32'(last_hit), 32'(0));

    // en toggling with everything valid; clr still honoured while disabled.
    step(1'b0, 1'b1, '1, '1, '0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, '1, '1, (k == 1) ? 4'b0100 : 4'b0000);
      check("en_off_ready", 32'(last_ready), 32'(0));
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, '1, '1, '0);

    // Reset mid-stream with ch3 in S2.
    do_reset();
    step(1'b0, 1'b1, 4'b1000, 4'b1000, '0);
    step(1'b0, 1'b1, 4'b1000, 4'b1000, '0);
    step(1'b1, 1'b1, '1, '1, '0);
    step(1'b0, 1'b1, '1, '1, '0);
    check("mid_rst_valid", 32'(last_valid), 32'(0));
    check("mid_rst_first", 32'(last_ready), 32'(4'b0001));
    step(1'b0, 1'b1, 4'b1000, 4'b1000, '0);
    idle();
    check("mid_rst_ch3_state", 32'(last_state), 32'(1));

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           NCH'($urandom_range(0, (1 << NCH) - 1)),
           NCH'($urandom_range(0, (1 << NCH) - 1)),
           ($urandom_range(0, 5) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
